// File: rtl/ifu_ift2icb_buf_if.sv
// Fetch-side and ICB-side handshake bundle for the IFU-to-ICB bridge.
// master drives requests and ICB responses; slave is the bridge itself.
interface ifu_ift2icb_buf_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;

    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic        ifu_rsp_err;
    logic [31:0] ifu_rsp_instr;

    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;

    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;

    logic        pipe_flush;
    logic        ifu_busy;

    modport master (
        output ifu_req_valid,
        output ifu_req_pc,
        output ifu_rsp_ready,
        output icb_cmd_ready,
        output icb_rsp_valid,
        output icb_rsp_err,
        output icb_rsp_rdata,
        output pipe_flush,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_err,
        input  ifu_rsp_instr,
        input  icb_cmd_valid,
        input  icb_cmd_addr,
        input  icb_rsp_ready,
        input  ifu_busy
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_req_pc,
        input  ifu_rsp_ready,
        input  icb_cmd_ready,
        input  icb_rsp_valid,
        input  icb_rsp_err,
        input  icb_rsp_rdata,
        input  pipe_flush,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_err,
        output ifu_rsp_instr,
        output icb_cmd_valid,
        output icb_cmd_addr,
        output icb_rsp_ready,
        output ifu_busy
    );
endinterface

// File: rtl/ifu_ift2icb_buf.sv
// IFU fetch -> ICB read bridge with credit-limited outstanding reads and an in-order response FIFO.
// Define IFT2ICB_BYPASS_EN for a zero-latency response path when the FIFO is empty.
module ifu_ift2icb_buf #(
    parameter int unsigned OUTS_DEPTH = 2,
    parameter int unsigned CNT_W      = $clog2(OUTS_DEPTH) + 1
) (
    input logic              clk,
    input logic              rst,
    ifu_ift2icb_buf_if.slave bus
);

    localparam int unsigned      PTR_W   = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTS_DEPTH);

    logic [CNT_W-1:0] outs_cnt_q, outs_cnt_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Entry layout: {err, instr}
    logic [32:0] fifo_mem [OUTS_DEPTH];

    logic        fifo_empty;
    logic        drop_zero;
    logic [CNT_W:0] occupancy;
    logic        credit_ok;
    logic        pc_aligned;
    logic        mis_ready;
    logic        cmd_fire;
    logic        mis_fire;
    logic        rsp_fire;
    logic        bypass;
    logic        push;
    logic        pop;
    logic [32:0] push_data;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign drop_zero  = (drop_cnt_q == '0);
    assign occupancy  = {1'b0, outs_cnt_q} + {1'b0, fifo_cnt_q};
    assign credit_ok  = (occupancy < {1'b0, DEPTH_C});
    assign pc_aligned = (bus.ifu_req_pc[1:0] == 2'b00);

    // Misaligned PCs wait for the bus to drain so the error entry lands in program order.
    assign mis_ready = (outs_cnt_q == '0) & drop_zero & (fifo_cnt_q < DEPTH_C) & ~bus.pipe_flush;

    // ---------------------------------------------------------------------------------------
    // Request side
    // ---------------------------------------------------------------------------------------
    assign bus.icb_cmd_valid = ~rst & bus.ifu_req_valid & pc_aligned & credit_ok & drop_zero
                             & ~bus.pipe_flush;
    assign bus.icb_cmd_addr  = bus.ifu_req_pc;

    always_comb begin
        bus.ifu_req_ready = 1'b0;
        if (!rst) begin
            if (pc_aligned) begin
                bus.ifu_req_ready = bus.icb_cmd_valid & bus.icb_cmd_ready;
            end else begin
                bus.ifu_req_ready = mis_ready;
            end
        end
    end

    assign cmd_fire = bus.icb_cmd_valid & bus.icb_cmd_ready;
    assign mis_fire = bus.ifu_req_valid & ~pc_aligned & bus.ifu_req_ready;

    // ---------------------------------------------------------------------------------------
    // ICB response side: credits guarantee FIFO room, so the bus is never back-pressured.
    // ---------------------------------------------------------------------------------------
    assign bus.icb_rsp_ready = ~rst;
    assign rsp_fire          = bus.icb_rsp_valid & bus.icb_rsp_ready;

`ifdef IFT2ICB_BYPASS_EN
    assign bypass = rsp_fire & fifo_empty & drop_zero & bus.ifu_rsp_ready & ~bus.pipe_flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = (rsp_fire & drop_zero & ~bus.pipe_flush & ~bypass) | mis_fire;
    assign pop  = ~fifo_empty & bus.ifu_rsp_ready & ~bus.pipe_flush;

    always_comb begin
        push_data = {bus.icb_rsp_err, bus.icb_rsp_rdata};
        if (mis_fire) begin
            push_data = {1'b1, 32'h0000_0000};
        end
    end

    // ---------------------------------------------------------------------------------------
    // Fetch response output
    // ---------------------------------------------------------------------------------------
    always_comb begin
        bus.ifu_rsp_valid                    = ~fifo_empty;
        {bus.ifu_rsp_err, bus.ifu_rsp_instr} = fifo_mem[rd_ptr_q];
`ifdef IFT2ICB_BYPASS_EN
        if (bypass) begin
            bus.ifu_rsp_valid                    = 1'b1;
            {bus.ifu_rsp_err, bus.ifu_rsp_instr} = {bus.icb_rsp_err, bus.icb_rsp_rdata};
        end
`endif
    end

    assign bus.ifu_busy = (outs_cnt_q != '0) | ~fifo_empty | ~drop_zero;

    // ---------------------------------------------------------------------------------------
    // Next-state
    // ---------------------------------------------------------------------------------------
    always_comb begin
        outs_cnt_d = outs_cnt_q + CNT_W'(cmd_fire) - CNT_W'(rsp_fire);
        drop_cnt_d = drop_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (bus.pipe_flush) begin
            // Everything still on the bus becomes stale, minus a response landing right now.
            drop_cnt_d = outs_cnt_q - CNT_W'(rsp_fire);
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (rsp_fire && !drop_zero) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outs_cnt_q <= '0;
            fifo_cnt_q <= '0;
            drop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            outs_cnt_q <= outs_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push && !bus.pipe_flush) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Invariants
    // ---------------------------------------------------------------------------------------
    fifo_bound_a: assert property (@(posedge clk) disable iff (rst) fifo_cnt_q <= DEPTH_C);

    rsp_legal_a: assert property (@(posedge clk) disable iff (rst)
        bus.icb_rsp_valid |-> (outs_cnt_q != '0));

endmodule

// File: tb/tb_ifu_ift2icb_buf.sv
// Bench for ifu_ift2icb_buf: directed scenarios then random traffic, checked every cycle
// against a queue-based model of in-order fetch delivery.
module tb_ifu_ift2icb_buf;

    localparam int unsigned D = 2;

    logic clk = 1'b0;
    logic rst;

    ifu_ift2icb_buf_if bus ();

    ifu_ift2icb_buf #(
        .OUTS_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ICB slave: one entry per accepted read, {live, err, data}; dead entries were flushed.
    logic [33:0] slave_q [$];
    // Fetch responses owed to the IFU, oldest first, {err, instr}.
    logic [32:0] exp_q [$];

    logic        rsp_en;
    logic        nd_err;
    logic [31:0] nd_data;
    logic        last_fire;
    string       phase;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: present inputs, check outputs against the model, advance the model.
    task automatic cycle();
        int          outs;
        int          drops;
        int          live;
        int          fifo;
        logic        aligned;
        logic        exp_cmd_v;
        logic        exp_req_r;
        logic        exp_rsp_v;
        logic        req_fire;
        logic        rsp_fire;
        logic        pop;
        logic        flush;
        logic [33:0] s;
        logic [32:0] e;

        if (rsp_en && slave_q.size() != 0) begin
            s                 = slave_q[0];
            bus.icb_rsp_valid = 1'b1;
            bus.icb_rsp_err   = s[32];
            bus.icb_rsp_rdata = s[31:0];
        end else begin
            bus.icb_rsp_valid = 1'b0;
            bus.icb_rsp_err   = 1'($urandom_range(0, 1));
            bus.icb_rsp_rdata = $urandom;
        end
        #2;

        outs  = slave_q.size();
        drops = 0;
        for (int i = 0; i < slave_q.size(); i++) begin
            s = slave_q[i];
            if (!s[33]) drops++;
        end
        live = outs - drops;
        fifo = exp_q.size() - live;

        exp_rsp_v = (fifo != 0);
        check({phase, ":rsp_valid"}, 64'(bus.ifu_rsp_valid), 64'(exp_rsp_v));
        if (exp_rsp_v) begin
            check({phase, ":rsp_data"}, 64'({bus.ifu_rsp_err, bus.ifu_rsp_instr}), 64'(exp_q[0]));
        end
        check({phase, ":busy"}, 64'(bus.ifu_busy), 64'((outs != 0) || (fifo != 0)));

        aligned   = (bus.ifu_req_pc[1:0] == 2'b00);
        exp_cmd_v = bus.ifu_req_valid && aligned && (outs + fifo < int'(D)) && (drops == 0)
                    && !bus.pipe_flush;
        exp_req_r = aligned ? (exp_cmd_v && bus.icb_cmd_ready)
                            : ((outs == 0) && (fifo < int'(D)) && !bus.pipe_flush);
        check({phase, ":cmd_valid"}, 64'(bus.icb_cmd_valid), 64'(exp_cmd_v));
        if (exp_cmd_v) begin
            check({phase, ":cmd_addr"}, 64'(bus.icb_cmd_addr), 64'(bus.ifu_req_pc));
        end
        check({phase, ":req_ready"}, 64'(bus.ifu_req_ready), 64'(exp_req_r));
        check({phase, ":icb_rsp_ready"}, 64'(bus.icb_rsp_ready), 64'(1));

        req_fire  = bus.ifu_req_valid && exp_req_r;
        rsp_fire  = bus.icb_rsp_valid;
        pop       = exp_rsp_v && bus.ifu_rsp_ready && !bus.pipe_flush;
        flush     = bus.pipe_flush;
        last_fire = req_fire;

        @(posedge clk);
        #1;

        if (rsp_fire) s = slave_q.pop_front();
        if (pop) e = exp_q.pop_front();
        if (flush) begin
            exp_q.delete();
            for (int i = 0; i < slave_q.size(); i++) begin
                s         = slave_q[i];
                s[33]     = 1'b0;
                slave_q[i] = s;
            end
        end
        if (req_fire) begin
            if (aligned) begin
                slave_q.push_back({1'b1, nd_err, nd_data});
                exp_q.push_back({nd_err, nd_data});
            end else begin
                exp_q.push_back({1'b1, 32'h0000_0000});
            end
        end
    endtask

    initial begin
        rst               = 1'b1;
        rsp_en            = 1'b0;
        nd_err            = 1'b0;
        nd_data           = 32'h0;
        last_fire         = 1'b0;
        phase             = "reset";
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_0002;
        bus.ifu_rsp_ready = 1'b0;
        bus.icb_cmd_ready = 1'b1;
        bus.icb_rsp_valid = 1'b0;
        bus.icb_rsp_err   = 1'b0;
        bus.icb_rsp_rdata = 32'h0;
        bus.pipe_flush    = 1'b0;

        // Outputs held quiet while reset is high, whatever the request looks like.
        #12;
        check("reset:req_ready_mis", 64'(bus.ifu_req_ready), 64'(0));
        check("reset:rsp_valid", 64'(bus.ifu_rsp_valid), 64'(0));
        check("reset:busy", 64'(bus.ifu_busy), 64'(0));
        bus.ifu_req_pc = 32'h0000_0000;
        #1;
        check("reset:cmd_valid", 64'(bus.icb_cmd_valid), 64'(0));
        check("reset:req_ready_al", 64'(bus.ifu_req_ready), 64'(0));
        @(posedge clk);
        #1;
        rst               = 1'b0;
        bus.ifu_req_valid = 1'b0;

        // Single aligned fetch, response next cycle, delivered one cycle later.
        phase             = "t1";
        bus.ifu_rsp_ready = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0000;
        nd_data           = 32'h0000_0013;
        cycle();
        check("t1:accept", 64'(last_fire), 64'(1));
        bus.ifu_req_valid = 1'b0;
        rsp_en            = 1'b1;
        cycle();
        check("t1:rsp_valid_after", 64'(bus.ifu_rsp_valid), 64'(1));
        check("t1:instr", 64'({bus.ifu_rsp_err, bus.ifu_rsp_instr}), 64'({1'b0, 32'h13}));
        cycle();
        check("t1:idle", 64'(bus.ifu_busy), 64'(0));

        // Credit limit with responses and the fetch stage stalled.
        phase             = "t2";
        rsp_en            = 1'b0;
        bus.ifu_rsp_ready = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_0100;
        nd_data           = 32'h1111_0100;
        cycle();
        check("t2:accept0", 64'(last_fire), 64'(1));
        bus.ifu_req_pc = 32'h0000_0104;
        nd_data        = 32'h1111_0104;
        cycle();
        check("t2:accept1", 64'(last_fire), 64'(1));
        bus.ifu_req_pc = 32'h0000_0108;
        nd_data        = 32'h1111_0108;
        cycle();
        check("t2:credit_block", 64'(last_fire), 64'(0));
        rsp_en = 1'b1;
        cycle();
        cycle();
        check("t2:fifo_full_block", 64'(last_fire), 64'(0));
        rsp_en            = 1'b0;
        bus.ifu_rsp_ready = 1'b1;
        cycle();
        check("t2:pop_cycle_block", 64'(last_fire), 64'(0));
        bus.ifu_rsp_ready = 1'b0;
        cycle();
        check("t2:accept2", 64'(last_fire), 64'(1));
        bus.ifu_req_valid = 1'b0;
        rsp_en            = 1'b1;
        bus.ifu_rsp_ready = 1'b1;
        repeat (4) cycle();
        check("t2:idle", 64'(bus.ifu_busy), 64'(0));

        // Misaligned PC behind an outstanding read.
        phase             = "t3";
        rsp_en            = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_0200;
        nd_data           = 32'h2222_0200;
        cycle();
        bus.ifu_req_pc = 32'h0000_0102;
        cycle();
        check("t3:mis_block0", 64'(last_fire), 64'(0));
        cycle();
        check("t3:mis_block1", 64'(last_fire), 64'(0));
        rsp_en = 1'b1;
        cycle();
        check("t3:mis_block2", 64'(last_fire), 64'(0));
        rsp_en = 1'b0;
        cycle();
        check("t3:mis_accept", 64'(last_fire), 64'(1));
        check("t3:err_entry", 64'({bus.ifu_rsp_err, bus.ifu_rsp_instr}), 64'({1'b1, 32'h0}));
        bus.ifu_req_valid = 1'b0;
        cycle();
        check("t3:idle", 64'(bus.ifu_busy), 64'(0));

        // Bus error carries the read data through.
        phase             = "t4";
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_0300;
        nd_err            = 1'b1;
        nd_data           = 32'hDEAD_BEEF;
        cycle();
        bus.ifu_req_valid = 1'b0;
        rsp_en            = 1'b1;
        cycle();
        check("t4:err_rsp", 64'({bus.ifu_rsp_err, bus.ifu_rsp_instr}), 64'({1'b1, 32'hDEAD_BEEF}));
        nd_err = 1'b0;
        cycle();

        // Flush with two reads in flight.
        phase             = "t5";
        rsp_en            = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_0400;
        nd_data           = 32'h5555_0400;
        cycle();
        bus.ifu_req_pc = 32'h0000_0404;
        nd_data        = 32'h5555_0404;
        cycle();
        bus.ifu_req_valid = 1'b0;
        bus.pipe_flush    = 1'b1;
        cycle();
        bus.pipe_flush = 1'b0;
        check("t5:busy_drop", 64'(bus.ifu_busy), 64'(1));
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_0500;
        nd_data           = 32'h5555_0500;
        cycle();
        check("t5:block0", 64'(last_fire), 64'(0));
        rsp_en = 1'b1;
        cycle();
        check("t5:block1", 64'(last_fire), 64'(0));
        cycle();
        check("t5:block2", 64'(last_fire), 64'(0));
        cycle();
        check("t5:accept", 64'(last_fire), 64'(1));
        bus.ifu_req_valid = 1'b0;
        cycle();
        check("t5:new_rsp", 64'({bus.ifu_rsp_err, bus.ifu_rsp_instr}), 64'({1'b0, 32'h5555_0500}));
        cycle();

        // Asynchronous reset with one read outstanding and one entry queued.
        phase             = "t6";
        rsp_en            = 1'b0;
        bus.ifu_rsp_ready = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_0600;
        nd_data           = 32'h6666_0600;
        cycle();
        bus.ifu_req_valid = 1'b0;
        rsp_en            = 1'b1;
        cycle();
        rsp_en            = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_0604;
        cycle();
        check("t6:pre_busy", 64'(bus.ifu_busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("t6:rsp_valid", 64'(bus.ifu_rsp_valid), 64'(0));
        check("t6:busy", 64'(bus.ifu_busy), 64'(0));
        check("t6:cmd_valid", 64'(bus.icb_cmd_valid), 64'(0));
        slave_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst               = 1'b0;
        bus.ifu_req_valid = 1'b0;

        // Random traffic.
        phase = "rand";
        repeat (3000) begin
            bus.ifu_req_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.ifu_req_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'($urandom_range(1, 3))};
            end else begin
                bus.ifu_req_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            end
            bus.icb_cmd_ready = ($urandom_range(0, 3) != 0);
            rsp_en            = 1'($urandom_range(0, 1));
            bus.ifu_rsp_ready = ($urandom_range(0, 2) != 0);
            bus.pipe_flush    = ($urandom_range(0, 39) == 0);
            nd_err            = ($urandom_range(0, 15) == 0);
            nd_data           = $urandom;
            cycle();
        end

        phase             = "drain";
        bus.ifu_req_valid = 1'b0;
        bus.pipe_flush    = 1'b0;
        rsp_en            = 1'b1;
        bus.ifu_rsp_ready = 1'b1;
        repeat (10) cycle();
        check("drain:idle", 64'(bus.ifu_busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
